// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: FSM sequencing, ALU control, memory wait-state
// timeout and sticky illegal-instruction / bus-fault trapping.
module mc_controller #(
  parameter int unsigned TO_BITS = 4,
  parameter bit          EXT_ISA = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       memread,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       alusrca,
  output logic [2:0] alusrcb,
  output logic [2:0] alucont,
  output logic       regwrite,
  output logic [1:0] regdst,
  output logic [1:0] memtoreg,
  output logic [1:0] pcsource,
  output logic       pcen,
  output logic       illegal,
  output logic       busfault,
  output logic       halted
);

  typedef enum logic [3:0] {
    FETCH    = 4'b0000,
    DECODE   = 4'b0001,
    MEMADR   = 4'b0010,
    MEMRD    = 4'b0011,
    MEMWB    = 4'b0100,
    MEMWR    = 4'b0101,
    RTYPEEX  = 4'b0110,
    RTYPEWR  = 4'b0111,
    BRANCHEX = 4'b1000,
    JEX      = 4'b1001,
    IMMEX    = 4'b1010,
    IMMWR    = 4'b1011,
    JALEX    = 4'b1100,
    TRAP     = 4'b1111
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_e               state_q, state_d;
  logic [TO_BITS-1:0]   wcnt_q, wcnt_d;
  logic                 illegal_q, illegal_d;
  logic                 busfault_q, busfault_d;
  logic                 pcwrite, pcwritecond, waiting;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FETCH;
      wcnt_q     <= '0;
      illegal_q  <= 1'b0;
      busfault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      illegal_q  <= illegal_d;
      busfault_q <= busfault_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    illegal_d   = illegal_q;
    busfault_d  = busfault_q;
    wcnt_d      = '0;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    waiting     = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    iord        = 1'b0;
    irwrite     = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 3'b000;
    alucont     = 3'b000;
    regwrite    = 1'b0;
    regdst      = 2'b00;
    memtoreg    = 2'b00;
    pcsource    = 2'b00;
    pcen        = 1'b0;
    halted      = 1'b0;
    illegal     = illegal_q;
    busfault    = busfault_q;

    case (state_q)
      FETCH: begin
        memread = 1'b1;
        alusrcb = 3'b001;
        alucont = ALU_ADD;
        irwrite = memready;
        pcwrite = memready;
        waiting = 1'b1;
        if (memready) state_d = DECODE;
      end
      DECODE: begin
        alusrcb = 3'b011;
        alucont = ALU_ADD;
        state_d = TRAP;
        case (op)
          OP_LB, OP_SB: state_d = MEMADR;
          OP_BEQ:       state_d = BRANCHEX;
          OP_J:         state_d = JEX;
          OP_ADDI:      state_d = IMMEX;
          OP_BNE:       if (EXT_ISA) state_d = BRANCHEX;
          OP_JAL:       if (EXT_ISA) state_d = JALEX;
          OP_SLTI, OP_ANDI, OP_ORI: if (EXT_ISA) state_d = IMMEX;
          OP_RTYPE: begin
            if (funct == 6'b100000 || funct == 6'b100010 || funct == 6'b100100 ||
                funct == 6'b100101 || funct == 6'b101010)
              state_d = RTYPEEX;
          end
          default: state_d = TRAP;
        endcase
        if (state_d == TRAP) illegal_d = 1'b1;
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 3'b010;
        alucont = ALU_ADD;
        if (op == OP_SB) state_d = MEMWR;
        else             state_d = MEMRD;
      end
      MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        waiting = 1'b1;
        if (memready) state_d = MEMWB;
      end
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 2'b01;
        state_d  = FETCH;
      end
      MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        waiting  = 1'b1;
        if (memready) state_d = FETCH;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        case (funct)
          6'b100010: alucont = ALU_SUB;
          6'b100100: alucont = ALU_AND;
          6'b100101: alucont = ALU_OR;
          6'b101010: alucont = ALU_SLT;
          default:   alucont = ALU_ADD;
        endcase
        state_d = RTYPEWR;
      end
      RTYPEWR: begin
        regwrite = 1'b1;
        regdst   = 2'b01;
        state_d  = FETCH;
      end
      BRANCHEX: begin
        alusrca     = 1'b1;
        alucont     = ALU_SUB;
        pcsource    = 2'b01;
        pcwritecond = 1'b1;
        state_d     = FETCH;
      end
      JEX: begin
        pcwrite  = 1'b1;
        pcsource = 2'b10;
        state_d  = FETCH;
      end
      JALEX: begin
        pcwrite  = 1'b1;
        pcsource = 2'b10;
        regwrite = 1'b1;
        regdst   = 2'b10;
        memtoreg = 2'b10;
        state_d  = FETCH;
      end
      IMMEX: begin
        alusrca = 1'b1;
        case (op)
          OP_SLTI: begin alusrcb = 3'b010; alucont = ALU_SLT; end
          OP_ANDI: begin alusrcb = 3'b100; alucont = ALU_AND; end
          OP_ORI:  begin alusrcb = 3'b100; alucont = ALU_OR;  end
          default: begin alusrcb = 3'b010; alucont = ALU_ADD; end
        endcase
        state_d = IMMWR;
      end
      IMMWR: begin
        regwrite = 1'b1;
        state_d  = FETCH;
      end
      TRAP: begin
        halted = 1'b1;
      end
      default: state_d = TRAP;
    endcase

    // Timeout overrides the normal hold; the counter restarts on any state change.
    if (waiting && !memready && (&wcnt_q)) begin
      state_d    = TRAP;
      busfault_d = 1'b1;
    end
    if (waiting && !memready && (state_d == state_q)) wcnt_d = wcnt_q + TO_BITS'(1);

    pcen = pcwrite | (pcwritecond & (zero ^ (op == OP_BNE)));

    // Reset gates every output combinationally so an in-flight access drops at once.
    if (!reset) begin
      memread  = 1'b0;
      memwrite = 1'b0;
      iord     = 1'b0;
      irwrite  = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = 3'b000;
      alucont  = 3'b000;
      regwrite = 1'b0;
      regdst   = 2'b00;
      memtoreg = 2'b00;
      pcsource = 2'b00;
      pcen     = 1'b0;
      halted   = 1'b0;
      illegal  = 1'b0;
      busfault = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: instruction-level reference expands each
// instruction into per-cycle expected outputs for an EXT_ISA=1 and EXT_ISA=0 instance.
module tb_mc_controller;

  localparam int TO_CYC = 16;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LB   = 6'b100000;
  localparam logic [5:0] OP_SB   = 6'b101000;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       alusrca;
    logic [2:0] alusrcb;
    logic [2:0] alucont;
    logic       regwrite;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic [1:0] pcsource;
    logic       pcen;
    logic       illegal;
    logic       busfault;
    logic       halted;
  } ov_t;

  typedef struct {
    ov_t e1;
    ov_t e0;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1, rst0, zero, memready;
  logic [5:0] op, funct;

  logic memread_a, memwrite_a, iord_a, irwrite_a, alusrca_a, regwrite_a, pcen_a;
  logic illegal_a, busfault_a, halted_a;
  logic [2:0] alusrcb_a, alucont_a;
  logic [1:0] regdst_a, memtoreg_a, pcsource_a;
  logic memread_b, memwrite_b, iord_b, irwrite_b, alusrca_b, regwrite_b, pcen_b;
  logic illegal_b, busfault_b, halted_b;
  logic [2:0] alusrcb_b, alucont_b;
  logic [1:0] regdst_b, memtoreg_b, pcsource_b;
  ov_t out_a, out_b;

  mc_controller #(.TO_BITS(4), .EXT_ISA(1'b1)) dut_a (
    .clk(clk), .reset(rst1), .op(op), .funct(funct), .zero(zero), .memready(memready),
    .memread(memread_a), .memwrite(memwrite_a), .iord(iord_a), .irwrite(irwrite_a),
    .alusrca(alusrca_a), .alusrcb(alusrcb_a), .alucont(alucont_a), .regwrite(regwrite_a),
    .regdst(regdst_a), .memtoreg(memtoreg_a), .pcsource(pcsource_a), .pcen(pcen_a),
    .illegal(illegal_a), .busfault(busfault_a), .halted(halted_a)
  );

  mc_controller #(.TO_BITS(4), .EXT_ISA(1'b0)) dut_b (
    .clk(clk), .reset(rst0), .op(op), .funct(funct), .zero(zero), .memready(memready),
    .memread(memread_b), .memwrite(memwrite_b), .iord(iord_b), .irwrite(irwrite_b),
    .alusrca(alusrca_b), .alusrcb(alusrcb_b), .alucont(alucont_b), .regwrite(regwrite_b),
    .regdst(regdst_b), .memtoreg(memtoreg_b), .pcsource(pcsource_b), .pcen(pcen_b),
    .illegal(illegal_b), .busfault(busfault_b), .halted(halted_b)
  );

  assign out_a = {memread_a, memwrite_a, iord_a, irwrite_a, alusrca_a, alusrcb_a, alucont_a,
                  regwrite_a, regdst_a, memtoreg_a, pcsource_a, pcen_a, illegal_a, busfault_a,
                  halted_a};
  assign out_b = {memread_b, memwrite_b, iord_b, irwrite_b, alusrca_b, alusrcb_b, alucont_b,
                  regwrite_b, regdst_b, memtoreg_b, pcsource_b, pcen_b, illegal_b, busfault_b,
                  halted_b};

  exp_t  expq[$];
  string tagq[$];
  int    checks = 0;
  int    errors = 0;
  bit    act;
  bit    trapped;

  // Monitor: one expected record per cycle, compared on the falling edge.
  initial begin
    exp_t  e;
    string t;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        t = tagq.pop_front();
        checks++;
        if (out_a !== e.e1) begin
          errors++;
          $display("FAIL %s ext1 got=%h exp=%h", t, out_a, e.e1);
        end
        checks++;
        if (out_b !== e.e0) begin
          errors++;
          $display("FAIL %s ext0 got=%h exp=%h", t, out_b, e.e0);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  function automatic bit legal(bit ext, logic [5:0] o, logic [5:0] f);
    case (o)
      OP_LB, OP_SB, OP_BEQ, OP_J, OP_ADDI: return 1'b1;
      OP_R: return (f == 6'b100000 || f == 6'b100010 || f == 6'b100100 ||
                    f == 6'b100101 || f == 6'b101010);
      OP_BNE, OP_JAL, OP_SLTI, OP_ANDI, OP_ORI: return ext;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] r_alu(logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic ov_t fetch_v(bit rdy);
    ov_t v = '0;
    v.memread = 1'b1;
    v.alusrcb = 3'b001;
    v.alucont = 3'b010;
    v.irwrite = rdy;
    v.pcen    = rdy;
    return v;
  endfunction

  task automatic chk(input string n, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", n, got, exp);
    end
  endtask

  task automatic cyc(input bit mr, input bit z, input ov_t v, input string t);
    exp_t e;
    memready = mr;
    zero     = z;
    e.e1 = act ? v : '0;
    e.e0 = act ? '0 : v;
    expq.push_back(e);
    tagq.push_back(t);
    @(posedge clk);
    #1;
  endtask

  task automatic trap_seq(input bit il, input bit bf);
    ov_t v = '0;
    v.halted   = 1'b1;
    v.illegal  = il;
    v.busfault = bf;
    trapped = 1'b1;
    repeat (3) cyc(rb(), rb(), v, "trap");
  endtask

  task automatic waits(input ov_t v, input int n, input string t, output bit to);
    to = 1'b0;
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, rb(), v, t);
      if (i == TO_CYC - 1) begin
        to = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset(input int n);
    if (act) rst1 = 1'b0; else rst0 = 1'b0;
    repeat (n) cyc(rb(), rb(), '0, "reset");
    if (act) rst1 = 1'b1; else rst0 = 1'b1;
    trapped = 1'b0;
  endtask

  task automatic exec_instr(input logic [5:0] o, input logic [5:0] f, input bit z,
                            input int fw, input int mw);
    ov_t v;
    bit  to;
    op    = o;
    funct = f;
    waits(fetch_v(1'b0), fw, "fetch_wait", to);
    if (to) begin trap_seq(1'b0, 1'b1); return; end
    cyc(1'b1, rb(), fetch_v(1'b1), "fetch");
    v = '0; v.alusrcb = 3'b011; v.alucont = 3'b010;
    cyc(rb(), rb(), v, "decode");
    if (!legal(act, o, f)) begin trap_seq(1'b1, 1'b0); return; end
    case (o)
      OP_LB, OP_SB: begin
        v = '0; v.alusrca = 1'b1; v.alusrcb = 3'b010; v.alucont = 3'b010;
        cyc(rb(), rb(), v, "memadr");
        v = '0; v.iord = 1'b1;
        if (o == OP_LB) v.memread = 1'b1; else v.memwrite = 1'b1;
        waits(v, mw, "mem_wait", to);
        if (to) begin trap_seq(1'b0, 1'b1); return; end
        cyc(1'b1, rb(), v, "mem_done");
        if (o == OP_LB) begin
          v = '0; v.regwrite = 1'b1; v.memtoreg = 2'b01;
          cyc(rb(), rb(), v, "memwb");
        end
      end
      OP_R: begin
        v = '0; v.alusrca = 1'b1; v.alucont = r_alu(f);
        cyc(rb(), rb(), v, "rtype_ex");
        v = '0; v.regwrite = 1'b1; v.regdst = 2'b01;
        cyc(rb(), rb(), v, "rtype_wr");
      end
      OP_BEQ, OP_BNE: begin
        v = '0; v.alusrca = 1'b1; v.alucont = 3'b110; v.pcsource = 2'b01;
        v.pcen = z ^ (o == OP_BNE);
        cyc(rb(), z, v, "branch");
      end
      OP_J: begin
        v = '0; v.pcen = 1'b1; v.pcsource = 2'b10;
        cyc(rb(), rb(), v, "jump");
      end
      OP_JAL: begin
        v = '0; v.pcen = 1'b1; v.pcsource = 2'b10; v.regwrite = 1'b1;
        v.regdst = 2'b10; v.memtoreg = 2'b10;
        cyc(rb(), rb(), v, "jal");
      end
      default: begin
        v = '0; v.alusrca = 1'b1;
        v.alusrcb = (o == OP_ANDI || o == OP_ORI) ? 3'b100 : 3'b010;
        case (o)
          OP_SLTI: v.alucont = 3'b111;
          OP_ANDI: v.alucont = 3'b000;
          OP_ORI:  v.alucont = 3'b001;
          default: v.alucont = 3'b010;
        endcase
        cyc(rb(), rb(), v, "imm_ex");
        v = '0; v.regwrite = 1'b1;
        cyc(rb(), rb(), v, "imm_wr");
      end
    endcase
  endtask

  function automatic int pick_wait();
    int r = $urandom_range(0, 19);
    if (r < 16) return r % 4;
    case (r)
      16:      return 14;
      17:      return 15;
      18:      return 16;
      default: return 20;
    endcase
  endfunction

  task automatic random_stream(input int n);
    logic [5:0] ops [11];
    logic [5:0] fns [5];
    logic [5:0] o, f;
    ops = '{OP_LB, OP_SB, OP_R, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 11) == 11) o = 6'($urandom);
      else o = ops[$urandom_range(0, 10)];
      if ($urandom_range(0, 4) == 0) f = 6'($urandom);
      else f = fns[$urandom_range(0, 4)];
      exec_instr(o, f, rb(), pick_wait(), pick_wait());
      if (trapped) do_reset(2);
    end
  endtask

  initial begin
    act = 1'b1; trapped = 1'b0;
    rst1 = 1'b0; rst0 = 1'b0;
    memready = 1'b1; zero = 1'b0; op = '0; funct = '0;
    @(posedge clk);
    #1;
    do_reset(2);

    exec_instr(OP_ADDI, 6'b000101, 1'b0, 0, 0);
    exec_instr(OP_LB, 6'b000000, 1'b0, 0, 3);
    exec_instr(OP_ADDI, 6'b000000, 1'b0, 16, 0);
    do_reset(2);
    exec_instr(OP_ADDI, 6'b000000, 1'b0, 15, 0);
    exec_instr(OP_BEQ, 6'b000000, 1'b1, 0, 0);
    exec_instr(OP_BEQ, 6'b000000, 1'b0, 1, 0);
    exec_instr(OP_BNE, 6'b000000, 1'b1, 0, 0);
    exec_instr(OP_BNE, 6'b000000, 1'b0, 2, 0);
    exec_instr(OP_JAL, 6'b000000, 1'b0, 0, 0);
    exec_instr(OP_R, 6'b000000, 1'b0, 0, 0);
    do_reset(2);
    exec_instr(OP_LB, 6'b000000, 1'b0, 0, 16);
    do_reset(2);
    exec_instr(OP_SB, 6'b000000, 1'b0, 0, 15);

    // Asynchronous reset in the middle of a stalled store.
    op = OP_SB;
    cyc(1'b1, rb(), fetch_v(1'b1), "fetch");
    cyc(rb(), rb(), '{alusrcb: 3'b011, alucont: 3'b010, default: '0}, "decode");
    cyc(rb(), rb(), '{alusrca: 1'b1, alusrcb: 3'b010, alucont: 3'b010, default: '0}, "memadr");
    repeat (2) cyc(1'b0, rb(), '{memwrite: 1'b1, iord: 1'b1, default: '0}, "memwr_wait");
    memready = 1'b0;
    #2;
    chk("memwrite_before_reset", memwrite_a, 1'b1);
    rst1 = 1'b0;
    #1;
    chk("memwrite_async_drop", memwrite_a, 1'b0);
    chk("iord_async_drop", iord_a, 1'b0);
    @(posedge clk);
    #1;
    cyc(rb(), rb(), '0, "reset_hold");
    rst1 = 1'b1;
    exec_instr(OP_ADDI, 6'b000000, 1'b0, 15, 0);

    random_stream(150);

    act = 1'b0;
    rst1 = 1'b0;
    do_reset(2);
    exec_instr(OP_JAL, 6'b000000, 1'b0, 0, 0);
    do_reset(2);
    exec_instr(OP_BNE, 6'b000000, 1'b0, 0, 0);
    do_reset(2);
    exec_instr(OP_ORI, 6'b000000, 1'b0, 0, 0);
    do_reset(2);
    exec_instr(OP_ADDI, 6'b000000, 1'b0, 0, 0);
    exec_instr(OP_BEQ, 6'b000000, 1'b1, 0, 0);
    exec_instr(OP_R, 6'b101010, 1'b0, 1, 0);
    random_stream(60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
